// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// The datapath drives the DOF operand fields and branch resolution; the controller returns holds, bubble, flush and status.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             DOF_VALID;
    logic [4:0]       DOF_AA;
    logic [4:0]       DOF_BA;
    logic             DOF_USE_A;
    logic             DOF_USE_B;
    logic             DOF_RW;
    logic [4:0]       DOF_DA;
    logic             BR_TAKEN;

    logic             PC_HOLD;
    logic             IR_HOLD;
    logic             DOF_BUBBLE;
    logic             FLUSH;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_TOTAL;
    logic [CNT_W-1:0] FLUSH_TOTAL;

    modport master (
        output DOF_VALID, DOF_AA, DOF_BA, DOF_USE_A, DOF_USE_B, DOF_RW, DOF_DA, BR_TAKEN,
        input  PC_HOLD, IR_HOLD, DOF_BUBBLE, FLUSH, STATE, STALL_TOTAL, FLUSH_TOTAL
    );

    modport slave (
        input  DOF_VALID, DOF_AA, DOF_BA, DOF_USE_A, DOF_USE_B, DOF_RW, DOF_DA, BR_TAKEN,
        output PC_HOLD, IR_HOLD, DOF_BUBBLE, FLUSH, STATE, STALL_TOTAL, FLUSH_TOTAL
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 4-stage pipeline: RAW detection against EX/WB writers,
// taken-branch flushing for NUM_FLUSH cycles, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int NUM_FLUSH = 2,
    parameter int CNT_W     = 16
) (
    input logic               CLOCK,
    input logic               RESET,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(NUM_FLUSH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_next;

    logic             r_ex_rw;
    logic [4:0]       r_ex_da;
    logic             r_wb_rw;
    logic [4:0]       r_wb_da;

    logic [CNT_W-1:0] r_stall_total;
    logic [CNT_W-1:0] r_flush_total;

    logic [1:0]       w_src_use;
    logic [4:0]       w_src_addr [2];
    logic [1:0]       w_src_hit;

    logic             w_in_flush;
    logic             w_raw_hazard;
    logic             w_hazard;
    logic             w_branch;
    logic             w_stall;

    logic             w_pc_hold;
    logic             w_ir_hold;
    logic             w_bubble;
    logic             w_flush;

    assign w_src_use     = {bus.DOF_USE_B, bus.DOF_USE_A};
    assign w_src_addr[0] = bus.DOF_AA;
    assign w_src_addr[1] = bus.DOF_BA;

    // R0 is hard-wired zero, so a read of it can never depend on an in-flight write.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_src_hit[gi] = w_src_use[gi]
                                 & (w_src_addr[gi] != 5'd0)
                                 & ((r_ex_rw & (w_src_addr[gi] == r_ex_da))
                                  | (r_wb_rw & (w_src_addr[gi] == r_wb_da)));
        end
    endgenerate

    assign w_in_flush   = (r_state == ST_FLUSH);
    assign w_raw_hazard = bus.DOF_VALID & (|w_src_hit);
    assign w_hazard     = w_raw_hazard & ~w_in_flush;
    assign w_branch     = bus.BR_TAKEN & ~w_in_flush;
    assign w_stall      = w_hazard & ~w_branch;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_RUN;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    // The branch cycle itself flushes, so FLUSH state lasts NUM_FLUSH-1 further cycles.
    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        case (r_state)
            ST_FLUSH: begin
                if (r_fcnt <= 3'd1) begin
                    w_fcnt_next  = 3'd0;
                    w_state_next = w_raw_hazard ? ST_STALL : ST_RUN;
                end else begin
                    w_fcnt_next  = r_fcnt - 3'd1;
                end
            end
            default: begin
                if (w_branch) begin
                    w_fcnt_next  = FLUSH_LOAD;
                    w_state_next = (FLUSH_LOAD == 3'd0) ? ST_RUN : ST_FLUSH;
                end else if (w_hazard) begin
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        w_pc_hold = 1'b0;
        w_ir_hold = 1'b0;
        w_bubble  = 1'b0;
        w_flush   = 1'b0;
        if (RESET) begin
            if (w_in_flush || w_branch) begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
            end else if (w_hazard) begin
                w_pc_hold = 1'b1;
                w_ir_hold = 1'b1;
                w_bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_ex_rw <= 1'b0;
            r_ex_da <= 5'd0;
            r_wb_rw <= 1'b0;
            r_wb_da <= 5'd0;
        end else begin
            r_wb_rw <= r_ex_rw;
            r_wb_da <= r_ex_da;
            if (w_bubble) begin
                r_ex_rw <= 1'b0;
                r_ex_da <= 5'd0;
            end else begin
                r_ex_rw <= bus.DOF_RW & bus.DOF_VALID;
                r_ex_da <= bus.DOF_DA;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_stall_total <= '0;
            r_flush_total <= '0;
        end else begin
            if (w_stall && (r_stall_total != CNT_MAX)) begin
                r_stall_total <= r_stall_total + CNT_W'(1);
            end
            if (w_branch && (r_flush_total != CNT_MAX)) begin
                r_flush_total <= r_flush_total + CNT_W'(1);
            end
        end
    end

    assign bus.PC_HOLD     = w_pc_hold;
    assign bus.IR_HOLD     = w_ir_hold;
    assign bus.DOF_BUBBLE  = w_bubble;
    assign bus.FLUSH       = w_flush;
    assign bus.STATE       = r_state;
    assign bus.STALL_TOTAL = r_stall_total;
    assign bus.FLUSH_TOTAL = r_flush_total;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a 16-bit-counter instance and a 4-bit-counter twin share stimulus;
// expected responses come from a register-list model and are checked by an independent monitor.
module tb_pipe_hazard_ctrl;
    localparam int NF = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  bus2 ();

    assign bus2.DOF_VALID = bus.DOF_VALID;
    assign bus2.DOF_AA    = bus.DOF_AA;
    assign bus2.DOF_BA    = bus.DOF_BA;
    assign bus2.DOF_USE_A = bus.DOF_USE_A;
    assign bus2.DOF_USE_B = bus.DOF_USE_B;
    assign bus2.DOF_RW    = bus.DOF_RW;
    assign bus2.DOF_DA    = bus.DOF_DA;
    assign bus2.BR_TAKEN  = bus.BR_TAKEN;

    pipe_hazard_ctrl #(.NUM_FLUSH(NF), .CNT_W(16)) dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    pipe_hazard_ctrl #(.NUM_FLUSH(NF), .CNT_W(4)) dut_sat (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic       pc;
        logic       ir;
        logic       bub;
        logic       fl;
        logic [1:0] st;
        int         stall;
        int         flush;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;

    // Reference: list of destinations for the two instructions ahead of DOF (-1 = no write),
    // plus the number of flush-only cycles still owed after a branch.
    int   m_state, m_left, m_ex, m_wb, m_stall, m_fcnt;
    bit   m_last_hold;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_left      = 0;
        m_ex        = -1;
        m_wb        = -1;
        m_stall     = 0;
        m_fcnt      = 0;
        m_last_hold = 1'b0;
    endtask

    task automatic set_idle();
        bus.DOF_VALID = 1'b0;
        bus.DOF_AA    = 5'd0;
        bus.DOF_BA    = 5'd0;
        bus.DOF_USE_A = 1'b0;
        bus.DOF_USE_B = 1'b0;
        bus.DOF_RW    = 1'b0;
        bus.DOF_DA    = 5'd0;
        bus.BR_TAKEN  = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [4:0] aa, input logic [4:0] ba,
                         input bit ua, input bit ub, input bit rw,
                         input logic [4:0] da, input bit br);
        exp_t e;
        bit   raw;
        bit   in_flush;
        int   nxt;
        @(posedge clk);
        #1;
        bus.DOF_VALID = v;
        bus.DOF_AA    = aa;
        bus.DOF_BA    = ba;
        bus.DOF_USE_A = ua;
        bus.DOF_USE_B = ub;
        bus.DOF_RW    = rw;
        bus.DOF_DA    = da;
        bus.BR_TAKEN  = br;

        e.pc = 0; e.ir = 0; e.bub = 0; e.fl = 0;
        e.st    = 2'(m_state);
        e.stall = m_stall;
        e.flush = m_fcnt;

        raw = v && ((ua && aa != 0 && (int'(aa) == m_ex || int'(aa) == m_wb)) ||
                    (ub && ba != 0 && (int'(ba) == m_ex || int'(ba) == m_wb)));
        in_flush = (m_left > 0);

        if (in_flush) begin
            e.fl = 1; e.bub = 1;
            m_left--;
            nxt = (m_left == 0) ? (raw ? 1 : 0) : 2;
        end else if (br) begin
            e.fl = 1; e.bub = 1;
            m_fcnt++;
            m_left = NF - 1;
            nxt = (m_left > 0) ? 2 : 0;
        end else if (raw) begin
            e.pc = 1; e.ir = 1; e.bub = 1;
            m_stall++;
            nxt = 1;
        end else begin
            nxt = 0;
        end

        m_wb    = m_ex;
        m_ex    = (e.bub || !(v && rw)) ? -1 : int'(da);
        m_state = nxt;
        m_last_hold = e.pc;
        q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    endtask

    task automatic wr(input logic [4:0] da);
        drive(1, 5'd0, 5'd0, 0, 0, 1, da, 0);
    endtask

    task automatic rd(input logic [4:0] aa, input bit ua, input logic [4:0] ba, input bit ub, input bit br);
        drive(1, aa, ba, ua, ub, 0, 5'd0, br);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc_hold"},  int'(bus.PC_HOLD),     0);
        chk({tag, "_ir_hold"},  int'(bus.IR_HOLD),     0);
        chk({tag, "_bubble"},   int'(bus.DOF_BUBBLE),  0);
        chk({tag, "_flush"},    int'(bus.FLUSH),       0);
        chk({tag, "_state"},    int'(bus.STATE),       0);
        chk({tag, "_stall"},    int'(bus.STALL_TOTAL), 0);
        chk({tag, "_flushcnt"}, int'(bus.FLUSH_TOTAL), 0);
        chk({tag, "_sat_stall"}, int'(bus2.STALL_TOTAL), 0);
        chk({tag, "_sat_state"}, int'(bus2.STATE),       0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                n_txn++;
                chk("pc_hold",     int'(bus.PC_HOLD),      int'(me.pc));
                chk("ir_hold",     int'(bus.IR_HOLD),      int'(me.ir));
                chk("dof_bubble",  int'(bus.DOF_BUBBLE),   int'(me.bub));
                chk("flush",       int'(bus.FLUSH),        int'(me.fl));
                chk("state",       int'(bus.STATE),        int'(me.st));
                chk("stall_total", int'(bus.STALL_TOTAL),  sat(me.stall, 16));
                chk("flush_total", int'(bus.FLUSH_TOTAL),  sat(me.flush, 16));
                chk("sat_stall",   int'(bus2.STALL_TOTAL), sat(me.stall, 4));
                chk("sat_flush",   int'(bus2.FLUSH_TOTAL), sat(me.flush, 4));
                chk("sat_flushout", int'(bus2.FLUSH),      int'(me.fl));
                $display("txn %0d state=%0d pc_hold=%0d bubble=%0d flush=%0d stall_total=%0d flush_total=%0d sat_stall=%0d",
                         n_txn, bus.STATE, bus.PC_HOLD, bus.DOF_BUBBLE, bus.FLUSH,
                         bus.STALL_TOTAL, bus.FLUSH_TOTAL, bus2.STALL_TOTAL);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         v, ua, ub, rw, br;
        logic [4:0] aa, ba, da;

        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // RAW on the EX writer: two stall cycles while the writer drains EX then WB
        wr(5'd5);
        repeat (3) rd(5'd5, 1, 5'd0, 0, 0);
        repeat (2) idle();

        // R0 writer/reader and an unused B operand never stall
        wr(5'd0);
        rd(5'd0, 1, 5'd0, 0, 0);
        wr(5'd5);
        rd(5'd7, 1, 5'd5, 0, 0);
        repeat (2) idle();

        // Taken branch, with a second pulse inside the flush window
        drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        repeat (2) idle();

        // Branch wins over a simultaneous hazard
        wr(5'd9);
        rd(5'd9, 1, 5'd0, 0, 1);
        repeat (3) idle();

        // Reset asserted in the second flush cycle
        drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        @(posedge clk);
        #1;
        bus.DOF_VALID = 1'b1;
        bus.BR_TAKEN  = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle();

        // 20 stall cycles drive the 4-bit twin into saturation
        for (int k = 0; k < 10; k++) begin
            wr(5'd3);
            repeat (3) rd(5'd0, 0, 5'd3, 1, 0);
        end
        repeat (3) idle();

        // Random traffic over a small register window to provoke frequent hazards
        v = 0; ua = 0; ub = 0; rw = 0; aa = 0; ba = 0; da = 0;
        for (int i = 0; i < 400; i++) begin
            if (!m_last_hold) begin
                v  = ($urandom_range(0, 9) < 8);
                aa = 5'($urandom_range(0, 3));
                ba = 5'($urandom_range(0, 3));
                ua = 1'($urandom_range(0, 1));
                ub = 1'($urandom_range(0, 1));
                rw = 1'($urandom_range(0, 1));
                da = 5'($urandom_range(0, 3));
            end
            br = ($urandom_range(0, 11) == 0);
            drive(v, aa, ba, ua, ub, rw, da, br);
        end
        repeat (3) idle();

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        chk("queue_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: NUM_FLUSH, 2, number of cycles IF/DOF are flushed after a taken branch (legal 1..7).
REQ-002 SHALL have parameter: CNT_W, 16, width of the saturating event counters.
REQ-003 SHALL have port: CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: DOF_VALID  input  1  instruction present in DOF stage.
REQ-006 SHALL have ports: DOF_AA, DOF_BA  input  5 each  source register addresses of the DOF instruction.
REQ-007 SHALL have ports: DOF_USE_A, DOF_USE_B  input  1 each  DOF instruction reads A / B register.
REQ-008 SHALL have ports: DOF_RW  input  1, DOF_DA  input  5  register-write enable and destination of the DOF instruction.
REQ-009 SHALL have port: BR_TAKEN  input  1  EX stage resolved a taken branch or jump this cycle.
REQ-010 SHALL have ports: PC_HOLD, IR_HOLD  output  1 each  freeze PC and IF/DOF pipeline register.
REQ-011 SHALL have port: DOF_BUBBLE  output  1  force RW=0, MW=0 into the DOF/EX register.
REQ-012 SHALL have port: FLUSH  output  1  kill the IF and DOF instructions.
REQ-013 SHALL have port: STATE  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-014 SHALL have ports: STALL_TOTAL, FLUSH_TOTAL  output  CNT_W each  saturating event counters.

Function
REQ-015 SHALL keep a two-entry scoreboard {ex_rw, ex_da} and {wb_rw, wb_da} for the instructions in EX and WB.
REQ-016 SHALL, each edge, shift: wb <= ex; ex <= {DOF_RW & DOF_VALID, DOF_DA}, or ex <= {0, 0} when DOF_BUBBLE=1.
REQ-017 SHALL detect a hazard combinationally when all hold: DOF_VALID=1; state is not FLUSH; the used source address (A and/or B) is nonzero; and it equals ex_da with ex_rw=1, or wb_da with wb_rw=1.
REQ-018 SHALL never flag a hazard on R0.
REQ-019 SHALL, in a hazard cycle with BR_TAKEN=0, assert PC_HOLD=1, IR_HOLD=1 and DOF_BUBBLE=1 in that same cycle.
REQ-020 SHALL resolve any hazard within 2 stall cycles because bubbles drain the scoreboard; no timeout is required.
REQ-021 SHALL treat BR_TAKEN=1 in RUN or STALL as taking priority over a hazard: PC_HOLD=0, IR_HOLD=0, FLUSH=1, DOF_BUBBLE=1 that cycle.
REQ-022 SHALL, after a taken branch, enter FLUSH with a down-counter loaded with NUM_FLUSH-1.
REQ-023 SHALL, in FLUSH, assert FLUSH=1 and DOF_BUBBLE=1 and hold PC_HOLD=IR_HOLD=0.
REQ-024 SHALL, in FLUSH, decrement the counter each cycle and exit when it reaches 0 (FLUSH asserted NUM_FLUSH cycles in total).
REQ-025 SHALL ignore BR_TAKEN while in FLUSH.
REQ-026 SHALL exit FLUSH at counter 0 to STALL if a hazard exists that cycle, else to RUN.
REQ-027 SHALL go from RUN/STALL to STALL on a hazard and to RUN when no hazard is present.
REQ-028 SHALL make STATE the registered state, so it reflects the action taken in the previous cycle.
REQ-029 SHALL increment STALL_TOTAL once per hazard-stall cycle and FLUSH_TOTAL once per taken branch.
REQ-030 SHALL saturate both counters at 2^CNT_W-1 with no wrap.
REQ-031 SHALL keep all outputs at 0 whenever DOF_VALID=0, outside FLUSH and without BR_TAKEN.

Reset
REQ-032 SHALL, while RESET=0, immediately clear the scoreboard, FLUSH counter, STATE (RUN), PC_HOLD, IR_HOLD, DOF_BUBBLE, FLUSH, STALL_TOTAL and FLUSH_TOTAL to 0, independent of CLOCK.
REQ-033 SHALL abandon a flush or stall in progress when reset is asserted, and resume in RUN with an empty scoreboard on the first edge after RESET=1.

Verification
REQ-034 SHALL verify RAW on EX: cycle n DOF_RW=1, DA=5; cycle n+1 AA=5, USE_A=1 -> PC_HOLD=IR_HOLD=DOF_BUBBLE=1 for 2 cycles, then 0; STALL_TOTAL=2.
REQ-035 SHALL verify R0 and unused operands: DA=0 writer then AA=0 reader; also BA=5 with USE_B=0 -> no stall, STALL_TOTAL=0.
REQ-036 SHALL verify the branch: BR_TAKEN=1 one cycle with NUM_FLUSH=2 -> FLUSH=1 for 2 cycles, STATE=10 then 00, FLUSH_TOTAL=1, and a BR_TAKEN pulse during FLUSH is ignored.
REQ-037 SHALL verify branch-over-hazard: hazard and BR_TAKEN in the same cycle -> PC_HOLD=0, FLUSH=1, STALL_TOTAL unchanged.
REQ-038 SHALL verify mid-flush reset: RESET=0 in the 2nd FLUSH cycle -> all outputs 0 asynchronously, STATE=00 after release.
REQ-039 SHALL verify saturation: CNT_W=4 with 20 stall cycles -> STALL_TOTAL=15 and held there.
